// File: rtl/falafel_alloc_fsm.sv
// First-fit malloc engine: walks the singly linked free list through the LSU header port under LOCK/UNLOCK.
// Latency: 1 cycle to respond for a bad size, otherwise 1 issue cycle + LSU latency per op, plus 1 cycle each for CHECK and FIT.
// Backpressure: LSU request fields are held until lsu_ready_i; the result is held until alloc_rsp_rdy_i; new requests are accepted only in IDLE.
//
// Ports: clk_i/rst_ni (async active-low); alloc_req_* client request (val/rdy/size);
//        alloc_rsp_* client result (val/rdy/ok/addr); lsu_req_o/lsu_ready_i LSU request;
//        lsu_rsp_i/lsu_rsp_rdy_o LSU response.
// Build option: define FALAFEL_SPLIT_EN to split oversized blocks; when undefined, every fit unlinks the whole block.

package falafel_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        LSU_LOAD                    = 3'd0,
        LSU_LOCK                    = 3'd1,
        LSU_UNLOCK                  = 3'd2,
        LSU_EDIT_NEXT_ADDR          = 3'd3,
        LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd4
    } lsu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_t;

    typedef struct packed {
        logic    val;
        lsu_op_e lsu_op;
        header_t header;
    } header_req_t;

    typedef struct packed {
        logic    val;
        header_t header;
    } header_rsp_t;
endpackage

module falafel_alloc_fsm
    import falafel_pkg::*;
#(
    parameter logic [DATA_W-1:0] HEAD_ADDR    = '0,
    parameter int unsigned       HEADER_BYTES = 16,
    parameter int unsigned       ALIGN        = 8,
    parameter int unsigned       MIN_BLOCK    = 32,
    parameter int unsigned       MAX_WALK     = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_req_val_i,
    output logic              alloc_req_rdy_o,
    input  logic [DATA_W-1:0] alloc_req_size_i,
    output logic              alloc_rsp_val_o,
    input  logic              alloc_rsp_rdy_i,
    output logic              alloc_rsp_ok_o,
    output logic [DATA_W-1:0] alloc_rsp_addr_o,
    output header_req_t       lsu_req_o,
    input  logic              lsu_ready_i,
    input  header_rsp_t       lsu_rsp_i,
    output logic              lsu_rsp_rdy_o
);

    localparam int CNT_W = $clog2(MAX_WALK + 1);
    localparam logic [DATA_W:0]   NEED_ADD   = (DATA_W+1)'(HEADER_BYTES + ALIGN - 1);
    localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(ALIGN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOCK, S_LD_HEAD, S_CHECK, S_LD_CUR, S_FIT,
        S_SPLIT_NEW, S_LINK, S_MARK, S_UNLOCK, S_RESPOND
    } state_e;

    state_e            state_q, state_d;
    logic              wait_q, wait_d;     // 0 = ISSUE phase, 1 = WAIT phase of the current LSU op
    logic [DATA_W-1:0] need_q, need_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] csize_q, csize_d;
    logic [DATA_W-1:0] cnext_q, cnext_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ok_q, ok_d;
    logic              split_q, split_d;

    // Rounded block size; the extra top bit catches sizes that wrap the address space.
    logic [DATA_W:0]   need_sum;
    logic [DATA_W-1:0] need_val;
    logic              need_fail;

    assign need_sum  = {1'b0, alloc_req_size_i} + NEED_ADD;
    assign need_val  = need_sum[DATA_W-1:0] & ALIGN_MASK;
    assign need_fail = need_sum[DATA_W] || (alloc_req_size_i == '0);

    // LSU request decode: which op the current state owns and its header fields.
    logic    has_op;
    lsu_op_e req_op;
    header_t req_hdr;
    logic    rsp_fire;

    always_comb begin
        has_op  = 1'b1;
        req_op  = LSU_LOAD;
        req_hdr = '0;
        case (state_q)
            S_LOCK: begin
                req_op       = LSU_LOCK;
                req_hdr.addr = HEAD_ADDR;
            end
            S_LD_HEAD: begin
                req_op       = LSU_LOAD;
                req_hdr.addr = HEAD_ADDR;
            end
            S_LD_CUR: begin
                req_op       = LSU_LOAD;
                req_hdr.addr = cur_q;
            end
`ifdef FALAFEL_SPLIT_EN
            S_SPLIT_NEW: begin
                req_op            = LSU_EDIT_SIZE_AND_NEXT_ADDR;
                req_hdr.addr      = cur_q + need_q;
                req_hdr.size      = csize_q - need_q;
                req_hdr.next_addr = cnext_q;
            end
`endif
            S_LINK: begin
                req_op            = LSU_EDIT_NEXT_ADDR;
                req_hdr.addr      = prev_q;
                req_hdr.next_addr = link_q;
            end
            S_MARK: begin
                req_op            = LSU_EDIT_SIZE_AND_NEXT_ADDR;
                req_hdr.addr      = cur_q;
                req_hdr.size      = split_q ? need_q : csize_q;
                req_hdr.next_addr = '0;
            end
            S_UNLOCK: begin
                req_op       = LSU_UNLOCK;
                req_hdr.addr = HEAD_ADDR;
            end
            default: has_op = 1'b0;
        endcase

        lsu_req_o = '0;
        if (has_op && !wait_q) begin
            lsu_req_o.val    = 1'b1;
            lsu_req_o.lsu_op = req_op;
            lsu_req_o.header = req_hdr;
        end
        lsu_rsp_rdy_o = has_op && wait_q;
    end

    assign rsp_fire = lsu_rsp_rdy_o && lsu_rsp_i.val;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        need_d  = need_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        csize_d = csize_q;
        cnext_d = cnext_q;
        link_d  = link_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        split_d = split_q;

        if (has_op && !wait_q && lsu_ready_i) begin
            wait_d = 1'b1;
        end
        if (rsp_fire) begin
            wait_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (alloc_req_val_i) begin
                    need_d  = need_val;
                    cnt_d   = '0;
                    ok_d    = 1'b0;
                    split_d = 1'b0;
                    state_d = need_fail ? S_RESPOND : S_LOCK;
                end
            end
            S_LOCK: begin
                if (rsp_fire) state_d = S_LD_HEAD;
            end
            S_LD_HEAD: begin
                if (rsp_fire) begin
                    prev_d  = HEAD_ADDR;
                    cur_d   = lsu_rsp_i.header.next_addr;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((cur_q == '0) || (cnt_q == CNT_W'(MAX_WALK))) begin
                    ok_d    = 1'b0;
                    state_d = S_UNLOCK;
                end else begin
                    state_d = S_LD_CUR;
                end
            end
            S_LD_CUR: begin
                if (rsp_fire) begin
                    csize_d = lsu_rsp_i.header.size;
                    cnext_d = lsu_rsp_i.header.next_addr;
                    cnt_d   = cnt_q + 1'b1;
                    if (lsu_rsp_i.header.size >= need_q) begin
                        state_d = S_FIT;
                    end else begin
                        prev_d  = cur_q;
                        cur_d   = lsu_rsp_i.header.next_addr;
                        state_d = S_CHECK;
                    end
                end
            end
            S_FIT: begin
`ifdef FALAFEL_SPLIT_EN
                // csize >= need here, so the subtraction cannot wrap.
                if ((csize_q - need_q) >= DATA_W'(MIN_BLOCK)) begin
                    split_d = 1'b1;
                    state_d = S_SPLIT_NEW;
                end else begin
                    link_d  = cnext_q;
                    state_d = S_LINK;
                end
`else
                link_d  = cnext_q;
                state_d = S_LINK;
`endif
            end
`ifdef FALAFEL_SPLIT_EN
            S_SPLIT_NEW: begin
                // Remainder header is written before anything points at it.
                if (rsp_fire) begin
                    link_d  = cur_q + need_q;
                    state_d = S_LINK;
                end
            end
`endif
            S_LINK: begin
                if (rsp_fire) state_d = S_MARK;
            end
            S_MARK: begin
                if (rsp_fire) begin
                    ok_d    = 1'b1;
                    state_d = S_UNLOCK;
                end
            end
            S_UNLOCK: begin
                if (rsp_fire) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                if (alloc_rsp_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            need_q  <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            csize_q <= '0;
            cnext_q <= '0;
            link_q  <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            need_q  <= need_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            csize_q <= csize_d;
            cnext_q <= cnext_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            split_q <= split_d;
        end
    end

    assign alloc_req_rdy_o  = (state_q == S_IDLE);
    assign alloc_rsp_val_o  = (state_q == S_RESPOND);
    assign alloc_rsp_ok_o   = alloc_rsp_val_o && ok_q;
    assign alloc_rsp_addr_o = (alloc_rsp_val_o && ok_q) ? (cur_q + DATA_W'(HEADER_BYTES)) : '0;

    // The response address field carries nothing the walk needs.
    logic unused_rsp_addr;
    assign unused_rsp_addr = ^lsu_rsp_i.header.addr;

`ifndef FALAFEL_SPLIT_EN
    logic unused_min_block;
    assign unused_min_block = ^MIN_BLOCK;
`endif

endmodule

// File: tb/tb_falafel_alloc_fsm.sv
module tb_falafel_alloc_fsm;
    import falafel_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alloc_req_val_i = 1'b0;
    logic        alloc_req_rdy_o;
    logic [31:0] alloc_req_size_i = '0;
    logic        alloc_rsp_val_o;
    logic        alloc_rsp_rdy_i = 1'b0;
    logic        alloc_rsp_ok_o;
    logic [31:0] alloc_rsp_addr_o;
    header_req_t lsu_req_o;
    logic        lsu_ready_i = 1'b0;
    header_rsp_t lsu_rsp_i = '0;
    logic        lsu_rsp_rdy_o;

    always #5 clk_i = ~clk_i;

    falafel_alloc_fsm dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .alloc_req_val_i  (alloc_req_val_i),
        .alloc_req_rdy_o  (alloc_req_rdy_o),
        .alloc_req_size_i (alloc_req_size_i),
        .alloc_rsp_val_o  (alloc_rsp_val_o),
        .alloc_rsp_rdy_i  (alloc_rsp_rdy_i),
        .alloc_rsp_ok_o   (alloc_rsp_ok_o),
        .alloc_rsp_addr_o (alloc_rsp_addr_o),
        .lsu_req_o        (lsu_req_o),
        .lsu_ready_i      (lsu_ready_i),
        .lsu_rsp_i        (lsu_rsp_i),
        .lsu_rsp_rdy_o    (lsu_rsp_rdy_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // ---------------- LSU + memory model ----------------
    typedef struct {
        lsu_op_e     op;
        logic [31:0] addr;
        logic [31:0] size;
        logic [31:0] next;
    } op_rec_t;

    op_rec_t     ops[$];
    logic [31:0] m_size[logic [31:0]];
    logic [31:0] m_next[logic [31:0]];
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    int          req_unstable = 0;
    header_req_t held_req;
    header_t     pend;
    logic        req_hs = 1'b0;
    logic        rsp_hs = 1'b0;

    function automatic logic [31:0] rd_size(input logic [31:0] a);
        return m_size.exists(a) ? m_size[a] : 32'h0;
    endfunction
    function automatic logic [31:0] rd_next(input logic [31:0] a);
        return m_next.exists(a) ? m_next[a] : 32'h0;
    endfunction

    task automatic mem_init();
        m_size.delete();
        m_next.delete();
        m_size[32'h0]   = 32'h0;   m_next[32'h0]   = 32'h100;
        m_size[32'h100] = 32'h40;  m_next[32'h100] = 32'h200;
        m_size[32'h200] = 32'h400; m_next[32'h200] = 32'h0;
        ops.delete();
        req_unstable = 0;
    endtask

    // Inputs are driven on the falling edge; DUT outputs are stable there.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            lsu_ready_i = 1'b0;
            lsu_rsp_i   = '0;
            req_hs      = 1'b0;
            rsp_hs      = 1'b0;
            stall_cnt   = 0;
        end else begin
            if (rsp_hs) begin
                lsu_rsp_i.val = 1'b0;
                rsp_hs = 1'b0;
            end
            if (req_hs) begin
                lsu_rsp_i.val    = 1'b1;
                lsu_rsp_i.header = pend;
                req_hs = 1'b0;
            end
            if (lsu_rsp_i.val && lsu_rsp_rdy_o) rsp_hs = 1'b1;
            if (lsu_req_o.val) begin
                if (stall_cnt == 0) held_req = lsu_req_o;
                else if (lsu_req_o !== held_req) req_unstable++;
                if (stall_cnt < stall_cycles) begin
                    lsu_ready_i = 1'b0;
                    stall_cnt++;
                end else begin
                    op_rec_t r;
                    lsu_ready_i = 1'b1;
                    stall_cnt = 0;
                    req_hs = 1'b1;
                    r.op   = lsu_req_o.lsu_op;
                    r.addr = lsu_req_o.header.addr;
                    r.size = lsu_req_o.header.size;
                    r.next = lsu_req_o.header.next_addr;
                    ops.push_back(r);
                    pend = lsu_req_o.header;
                    case (r.op)
                        LSU_LOAD: begin
                            pend.size      = rd_size(r.addr);
                            pend.next_addr = rd_next(r.addr);
                        end
                        LSU_EDIT_NEXT_ADDR: m_next[r.addr] = r.next;
                        LSU_EDIT_SIZE_AND_NEXT_ADDR: begin
                            m_size[r.addr] = r.size;
                            m_next[r.addr] = r.next;
                        end
                        default: pend = '0;
                    endcase
                end
            end else begin
                lsu_ready_i = 1'b0;
            end
        end
    end

    // ---------------- client driver ----------------
    task automatic run_alloc(input logic [31:0] size, input int hold,
                             output logic ok, output logic [31:0] addr,
                             output int lat, output logic stable, output logic tmo);
        int guard;
        tmo = 1'b0;
        stable = 1'b1;
        ok = 1'b0;
        addr = '0;
        @(negedge clk_i);
        guard = 0;
        while (!alloc_req_rdy_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        alloc_req_val_i  = 1'b1;
        alloc_req_size_i = size;
        @(negedge clk_i);
        alloc_req_val_i = 1'b0;
        lat = 1;
        while (!alloc_rsp_val_o && lat < 5000) begin
            @(negedge clk_i);
            lat++;
        end
        if (!alloc_rsp_val_o) begin
            tmo = 1'b1;
            return;
        end
        ok   = alloc_rsp_ok_o;
        addr = alloc_rsp_addr_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (!alloc_rsp_val_o || alloc_rsp_ok_o !== ok || alloc_rsp_addr_o !== addr || alloc_req_rdy_o)
                stable = 1'b0;
        end
        alloc_rsp_rdy_i = 1'b1;
        @(negedge clk_i);
        alloc_rsp_rdy_i = 1'b0;
        if (alloc_rsp_val_o || !alloc_req_rdy_o) stable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (alloc_req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy got %b want 1", alloc_req_rdy_o); end
        n_cmp++; if (alloc_rsp_val_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_val got %b want 0", alloc_rsp_val_o); end
        n_cmp++; if (alloc_rsp_ok_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ok got %b want 0", alloc_rsp_ok_o); end
        n_cmp++; if (alloc_rsp_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_addr got %h want 0", alloc_rsp_addr_o); end
        n_cmp++; if (lsu_req_o !== '0) begin n_fail++; $display("FAIL reset_lsu_req got %h want 0", lsu_req_o); end
        n_cmp++; if (lsu_rsp_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_rsp_rdy got %b want 0", lsu_rsp_rdy_o); end
    endtask

    task automatic test_small_fit();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        lsu_op_e     eo[6] = '{LSU_LOCK, LSU_LOAD, LSU_LOAD, LSU_EDIT_NEXT_ADDR, LSU_EDIT_SIZE_AND_NEXT_ADDR, LSU_UNLOCK};
        logic [31:0] ea[6] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h100, 32'h0};
        mem_init();
        stall_cycles = 0;
        run_alloc(32'h20, 0, ok, addr, lat, st, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL small_timeout got timeout want response"); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL small_ok got %b want 1", ok); end
        n_cmp++; if (addr !== 32'h110) begin n_fail++; $display("FAIL small_addr got %h want 110", addr); end
        n_cmp++; if (ops.size() != 6) begin n_fail++; $display("FAIL small_op_count got %0d want 6", ops.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= ops.size() || ops[i].op !== eo[i] || ops[i].addr !== ea[i]) begin
                n_fail++; $display("FAIL small_op%0d want op %0d addr %h (have %0d ops)", i, eo[i], ea[i], ops.size());
            end
        end
        n_cmp++; if (rd_next(32'h0) !== 32'h200) begin n_fail++; $display("FAIL small_head_next got %h want 200", rd_next(32'h0)); end
        n_cmp++; if (rd_size(32'h100) !== 32'h40) begin n_fail++; $display("FAIL small_blk_size got %h want 40", rd_size(32'h100)); end
        n_cmp++; if (rd_next(32'h100) !== 32'h0) begin n_fail++; $display("FAIL small_blk_next got %h want 0", rd_next(32'h100)); end
    endtask

    task automatic test_second_block();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        mem_init();
        stall_cycles = 0;
        run_alloc(32'h100, 0, ok, addr, lat, st, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL big_timeout got timeout want response"); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL big_ok got %b want 1", ok); end
        n_cmp++; if (addr !== 32'h210) begin n_fail++; $display("FAIL big_addr got %h want 210", addr); end
`ifdef FALAFEL_SPLIT_EN
        n_cmp++; if (ops.size() != 8) begin n_fail++; $display("FAIL big_op_count got %0d want 8", ops.size()); end
        n_cmp++; if (rd_size(32'h310) !== 32'h2F0 || rd_next(32'h310) !== 32'h0) begin
            n_fail++; $display("FAIL big_new_blk got size %h next %h want 2f0 0", rd_size(32'h310), rd_next(32'h310)); end
        n_cmp++; if (rd_next(32'h100) !== 32'h310) begin n_fail++; $display("FAIL big_prev_next got %h want 310", rd_next(32'h100)); end
        n_cmp++; if (rd_size(32'h200) !== 32'h110) begin n_fail++; $display("FAIL big_mark_size got %h want 110", rd_size(32'h200)); end
`else
        n_cmp++; if (ops.size() != 7) begin n_fail++; $display("FAIL big_op_count got %0d want 7", ops.size()); end
        n_cmp++; if (rd_next(32'h100) !== 32'h0) begin n_fail++; $display("FAIL big_prev_next got %h want 0", rd_next(32'h100)); end
        n_cmp++; if (rd_size(32'h200) !== 32'h400) begin n_fail++; $display("FAIL big_mark_size got %h want 400", rd_size(32'h200)); end
`endif
        n_cmp++; if (rd_next(32'h200) !== 32'h0) begin n_fail++; $display("FAIL big_mark_next got %h want 0", rd_next(32'h200)); end
    endtask

    task automatic test_no_fit();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        mem_init();
        stall_cycles = 0;
        run_alloc(32'h1000, 0, ok, addr, lat, st, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL nofit_timeout got timeout want response"); end
        n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL nofit_ok got %b want 0", ok); end
        n_cmp++; if (addr !== 32'h0) begin n_fail++; $display("FAIL nofit_addr got %h want 0", addr); end
        n_cmp++; if (ops.size() != 5) begin n_fail++; $display("FAIL nofit_op_count got %0d want 5", ops.size()); end
        n_cmp++; if (ops.size() < 5 || ops[3].addr !== 32'h200 || ops[4].op !== LSU_UNLOCK) begin
            n_fail++; $display("FAIL nofit_tail_ops want LOAD 200 then UNLOCK (have %0d ops)", ops.size()); end
        n_cmp++; if (rd_next(32'h0) !== 32'h100) begin n_fail++; $display("FAIL nofit_list_intact got %h want 100", rd_next(32'h0)); end
    endtask

    task automatic test_immediate_fail();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        logic [31:0] sizes[2] = '{32'h0, 32'hFFFF_FFF8};
        for (int k = 0; k < 2; k++) begin
            mem_init();
            run_alloc(sizes[k], 0, ok, addr, lat, st, tmo);
            n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL imm%0d_latency got %0d want 1", k, lat); end
            n_cmp++; if (ok !== 1'b0 || addr !== 32'h0) begin n_fail++; $display("FAIL imm%0d_result got ok %b addr %h want 0 0", k, ok, addr); end
            n_cmp++; if (ops.size() != 0) begin n_fail++; $display("FAIL imm%0d_lsu_ops got %0d want 0", k, ops.size()); end
        end
    endtask

    task automatic test_backpressure();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        mem_init();
        stall_cycles = 5;
        run_alloc(32'h20, 3, ok, addr, lat, st, tmo);
        stall_cycles = 0;
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL bp_timeout got timeout want response"); end
        n_cmp++; if (req_unstable != 0) begin n_fail++; $display("FAIL bp_req_stable got %0d changes want 0", req_unstable); end
        n_cmp++; if (ops.size() != 6) begin n_fail++; $display("FAIL bp_op_count got %0d want 6", ops.size()); end
        n_cmp++; if (ok !== 1'b1 || addr !== 32'h110) begin n_fail++; $display("FAIL bp_result got ok %b addr %h want 1 110", ok, addr); end
        n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_stable got %b want 1", st); end
    endtask

    task automatic test_reset_mid_walk();
        int guard = 0;
        mem_init();
        @(negedge clk_i);
        alloc_req_val_i  = 1'b1;
        alloc_req_size_i = 32'h1000;
        @(negedge clk_i);
        alloc_req_val_i = 1'b0;
        while (ops.size() < 3 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        n_cmp++; if (ops.size() < 3) begin n_fail++; $display("FAIL rstmid_walk_started got %0d ops want 3", ops.size()); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (alloc_req_rdy_o !== 1'b1 || alloc_rsp_val_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_alloc got rdy %b val %b want 1 0", alloc_req_rdy_o, alloc_rsp_val_o); end
        n_cmp++; if (alloc_rsp_ok_o !== 1'b0 || alloc_rsp_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_result got ok %b addr %h want 0 0", alloc_rsp_ok_o, alloc_rsp_addr_o); end
        n_cmp++; if (lsu_req_o !== '0 || lsu_rsp_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_lsu got req %h rsp_rdy %b want 0 0", lsu_req_o, lsu_rsp_rdy_o); end
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        logic ok, st, tmo; logic [31:0] addr; int lat;
        mem_init();
        run_alloc(32'h20, 0, ok, addr, lat, st, tmo);
        n_cmp++; if (tmo || ok !== 1'b1 || addr !== 32'h110) begin
            n_fail++; $display("FAIL b2b_first got tmo %b ok %b addr %h want 0 1 110", tmo, ok, addr); end
        run_alloc(32'h20, 0, ok, addr, lat, st, tmo);
        n_cmp++; if (tmo || ok !== 1'b1 || addr !== 32'h210) begin
            n_fail++; $display("FAIL b2b_second got tmo %b ok %b addr %h want 0 1 210", tmo, ok, addr); end
`ifdef FALAFEL_SPLIT_EN
        n_cmp++; if (rd_next(32'h0) !== 32'h230 || rd_size(32'h230) !== 32'h3D0) begin
            n_fail++; $display("FAIL b2b_list got head %h rem %h want 230 3d0", rd_next(32'h0), rd_size(32'h230)); end
`else
        n_cmp++; if (rd_next(32'h0) !== 32'h0 || rd_size(32'h200) !== 32'h400) begin
            n_fail++; $display("FAIL b2b_list got head %h size %h want 0 400", rd_next(32'h0), rd_size(32'h200)); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_fit();
        test_second_block();
        test_no_fit();
        test_immediate_fail();
        test_backpressure();
        test_reset_mid_walk();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
